opb_reg_bank_ctrl: RTL
======================

Name: opb_reg_bank_ctrl

Overview:
OPB slave-side controller that shares a single OPB slave attachment among N_SLV software-register slaves, such as the per-port gbe rx/tx counters and control registers. It performs these functions:
- decodes the address window;
- sequences one transaction at a time to the selected slave;
- enforces its own timeout;
- registers the returned read data and handshake back onto the OPB.

It sits between the OPB bus and a bank of register slaves.

Parameters:
N_SLV, 8, number of downstream register slaves (1..16)
C_BASEADDR, 32'h01088000, base byte address of slave 0
SPAN_LOG2, 8, log2 of the byte span per slave (256 bytes)
TIMEOUT, 16, ACCESS cycles before a forced error response (2..255)

Ports:
OPB_Clk  in  1  bus clock
OPB_Rst_n  in  1  asynchronous active-low reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; forwarded unregistered
OPB_DBus  in  [0:31]  write data; forwarded unregistered
OPB_RNW  in  1  1 = read
OPB_select  in  1  master select
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero except in the RESP cycle
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  error acknowledge
Sl_retry  out  1  retry
Sl_toutSup  out  1  timeout suppress
slv_select  out  N_SLV  one-hot select to the slaves
slv_ABus, slv_DBus, slv_BE, slv_RNW  out  32/32/4/1  pass-through of the OPB inputs
slv_rdata  in  N_SLV*32  concatenated slave read data; slave i occupies bits [32i+31:32i]
slv_xferAck, slv_errAck, slv_retry  in  N_SLV each  per-slave handshakes

Behaviour:
- Reset:
  - OPB_Rst_n low immediately forces the FSM to IDLE.
  - All registered outputs go to 0: Sl_*, slv_select, the idx register and the timer.
  - A reset mid-transaction aborts it with no ack.
- Hit condition:
  - OPB_select is high, and
  - C_BASEADDR <= OPB_ABus < C_BASEADDR + N_SLV<<SPAN_LOG2, using an unsigned 33-bit compare.
  - idx = (OPB_ABus - C_BASEADDR) >> SPAN_LOG2.
  - On a miss, the block drives nothing and all outputs stay 0, because other slaves share the OR-bus.
- FSM states: IDLE, ACCESS, RESP, GAP.
  - IDLE: on a hit, latch idx, clear the timer, set slv_select[idx] (registered) and go to ACCESS.
  - ACCESS:
    - slv_select[idx] = 1, Sl_toutSup = 1, timer increments each cycle.
    - slv_xferAck[idx]: latch slv_rdata[idx] into the data register (reads only; writes latch 0) and go to RESP with kind = ACK.
    - slv_errAck[idx]: go to RESP with kind = ERR.
    - slv_retry[idx]: go to RESP with kind = RETRY.
    - Otherwise, timer == TIMEOUT-1: go to RESP with kind = ERR.
    - Otherwise, OPB_select low (master abort): clear slv_select and go to IDLE with no response.
    - Priority when events coincide: xferAck > errAck > retry > timeout > abort. Handshakes from slaves other than idx are ignored.
  - RESP: one cycle, with slv_select already 0.
    - ACK: Sl_xferAck = 1 and Sl_DBus = latched data.
    - ERR: Sl_xferAck = 1, Sl_errAck = 1, Sl_DBus = 0.
    - RETRY: Sl_retry = 1, Sl_xferAck = 0.
    - Then go to GAP.
  - GAP: one cycle, all outputs 0. This prevents re-triggering on the same select while the master drops it. Then go to IDLE.
- Latency: minimum 3 cycles from the first OPB_select-high cycle to Sl_xferAck, when the slave acks in its first select cycle. Maximum is TIMEOUT+2 cycles.
- Output registers:
  - Sl_xferAck, Sl_errAck, Sl_retry, Sl_DBus and slv_select are all registered.
  - Sl_toutSup is decoded from the state register.
- Timer width is 8 bits and never wraps, because the timeout fires first.
- Back-to-back transactions are accepted from IDLE on the cycle after GAP.

Decomposition:
- Package opb_reg_bank_pkg holds:
  - the state enum {IDLE, ACCESS, RESP, GAP};
  - the response-kind enum {ACK, ERR, RETRY};
  - OPB_AW = 32 and OPB_DW = 32.
- One sub-module, opb_addr_decode, produces hit and idx from ABus, C_BASEADDR, SPAN_LOG2 and N_SLV. It is purely combinational.

Test Plan:
- Read hit: ABus = 32'h01088304 (idx 3), RNW = 1; slave 3 acks with 32'hDEADBEEF on its first select cycle. Expect slv_select = 8'b00001000 for 1 cycle, then Sl_xferAck for exactly 1 cycle at cycle 3 with Sl_DBus = 32'hDEADBEEF; Sl_DBus = 0 in every other cycle.
- Write hit: ABus = 32'h01088000, DBus = 32'h12345678; slave 0 acks after 4 cycles. Expect slv_DBus = 32'h12345678, Sl_xferAck at cycle 6, Sl_DBus = 0 and Sl_toutSup = 1 throughout ACCESS.
- Timeout: hit idx 7 and the slave never acks, with TIMEOUT = 16. Expect Sl_xferAck and Sl_errAck together at cycle 18; slv_select drops after 16 cycles.
- Miss: ABus = 32'h01089000 (idx would be 16). Expect all outputs to stay 0 for 32 cycles.
- Simultaneous events: slave 2 asserts xferAck and errAck in the same cycle that the timer hits TIMEOUT-1. Expect an ACK-only response. Separately, slave 5 retries: expect a 1-cycle Sl_retry with no Sl_xferAck.
- Abort and reset: drop OPB_select mid-ACCESS and expect IDLE with no ack. Then assert OPB_Rst_n low mid-ACCESS and expect all outputs 0 asynchronously; after release, the next hit completes normally.

Source files
------------

// File: rtl/opb_reg_bank_pkg.sv
// Shared types and widths for the OPB register-bank controller.
// OPB numbers bits big-endian (bit 0 = MSB); buses here are declared
// [W-1:0], so OPB bit 0 maps to bit W-1 and numeric values are unchanged.
package opb_reg_bank_pkg;

    localparam int unsigned OPB_AW  = 32;
    localparam int unsigned OPB_DW  = 32;
    localparam int unsigned OPB_BEW = 4;
    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        GAP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACK   = 2'd0,
        ERR   = 2'd1,
        RETRY = 2'd2
    } resp_kind_e;

    // Width of a slave index; a single slave still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/opb_addr_decode.sv
// Combinational window decode: is the address inside the bank, and which slave.
module opb_addr_decode
    import opb_reg_bank_pkg::*;
#(
    parameter int unsigned       N_SLV      = 8,
    parameter logic [OPB_AW-1:0] C_BASEADDR = 32'h01088000,
    parameter int unsigned       SPAN_LOG2  = 8,
    localparam int unsigned      IDX_W      = idx_width(N_SLV)
) (
    input  logic [OPB_AW-1:0] abus_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);

    localparam int unsigned     EXT_W  = OPB_AW + 1;
    // One extra bit so the window end cannot wrap past 2^32.
    localparam logic [EXT_W-1:0] WIN_LO = {1'b0, C_BASEADDR};
    localparam logic [EXT_W-1:0] WIN_HI = WIN_LO + (EXT_W'(N_SLV) << SPAN_LOG2);

    logic [EXT_W-1:0] addr_ext;

    assign addr_ext = {1'b0, abus_i};
    assign hit_o    = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign idx_o    = IDX_W'((abus_i - C_BASEADDR) >> SPAN_LOG2);

endmodule

// File: rtl/opb_reg_bank_ctrl.sv
// Shares one OPB slave attachment among N_SLV register slaves: decodes the
// window, runs one transaction at a time, times it out, and registers the
// response back onto the OPB.
module opb_reg_bank_ctrl
    import opb_reg_bank_pkg::*;
#(
    parameter int unsigned       N_SLV      = 8,
    parameter logic [OPB_AW-1:0] C_BASEADDR = 32'h01088000,
    parameter int unsigned       SPAN_LOG2  = 8,
    parameter int unsigned       TIMEOUT    = 16
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [OPB_AW-1:0]         OPB_ABus,
    input  logic [OPB_BEW-1:0]        OPB_BE,
    input  logic [OPB_DW-1:0]         OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [OPB_DW-1:0]         Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [N_SLV-1:0]          slv_select,
    output logic [OPB_AW-1:0]         slv_ABus,
    output logic [OPB_DW-1:0]         slv_DBus,
    output logic [OPB_BEW-1:0]        slv_BE,
    output logic                      slv_RNW,
    input  logic [N_SLV*OPB_DW-1:0]   slv_rdata,
    input  logic [N_SLV-1:0]          slv_xferAck,
    input  logic [N_SLV-1:0]          slv_errAck,
    input  logic [N_SLV-1:0]          slv_retry
);

    localparam int unsigned        IDX_W      = idx_width(N_SLV);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic                          dec_hit;
    logic [IDX_W-1:0]              dec_idx;
    logic [N_SLV-1:0][OPB_DW-1:0]  rdata_arr;
    logic [OPB_DW-1:0]             sel_rdata;

    state_e                        state_q;
    logic [IDX_W-1:0]              idx_q;
    logic [TIMER_W-1:0]            timer_q;
    logic [N_SLV-1:0]              slv_select_q;
    logic                          xfer_ack_q;
    logic                          err_ack_q;
    logic                          retry_q;
    logic [OPB_DW-1:0]             dbus_q;

    logic                          evt_c;
    resp_kind_e                    evt_kind_c;

    logic                          unused_seq_addr;

    opb_addr_decode #(
        .N_SLV      (N_SLV),
        .C_BASEADDR (C_BASEADDR),
        .SPAN_LOG2  (SPAN_LOG2)
    ) u_decode (
        .abus_i (OPB_ABus),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Sequential addresses carry no meaning for single-beat register access.
    assign unused_seq_addr = OPB_seqAddr;

    assign rdata_arr = slv_rdata;
    assign sel_rdata = rdata_arr[idx_q];

    // Pick the ACCESS-phase event for the selected slave, highest priority first.
    always_comb begin
        evt_c      = 1'b0;
        evt_kind_c = ACK;
        if (slv_xferAck[idx_q]) begin
            evt_c      = 1'b1;
            evt_kind_c = ACK;
        end else if (slv_errAck[idx_q]) begin
            evt_c      = 1'b1;
            evt_kind_c = ERR;
        end else if (slv_retry[idx_q]) begin
            evt_c      = 1'b1;
            evt_kind_c = RETRY;
        end else if (timer_q == TIMER_LAST) begin
            evt_c      = 1'b1;
            evt_kind_c = ERR;
        end
    end

    // Transaction FSM with registered slave select and OPB response.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            slv_select_q <= '0;
            xfer_ack_q   <= 1'b0;
            err_ack_q    <= 1'b0;
            retry_q      <= 1'b0;
            dbus_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (OPB_select && dec_hit) begin
                        idx_q        <= dec_idx;
                        timer_q      <= '0;
                        slv_select_q <= N_SLV'(1) << dec_idx;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    timer_q <= timer_q + TIMER_W'(1);
                    if (evt_c) begin
                        slv_select_q <= '0;
                        xfer_ack_q   <= (evt_kind_c != RETRY);
                        err_ack_q    <= (evt_kind_c == ERR);
                        retry_q      <= (evt_kind_c == RETRY);
                        dbus_q       <= ((evt_kind_c == ACK) && OPB_RNW) ? sel_rdata : '0;
                        state_q      <= RESP;
                    end else if (!OPB_select) begin
                        // Master gave up: leave quietly, no response on the bus.
                        slv_select_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                RESP: begin
                    xfer_ack_q <= 1'b0;
                    err_ack_q  <= 1'b0;
                    retry_q    <= 1'b0;
                    dbus_q     <= '0;
                    state_q    <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Sl_DBus    = dbus_q;
    assign Sl_xferAck = xfer_ack_q;
    assign Sl_errAck  = err_ack_q;
    assign Sl_retry   = retry_q;
    assign Sl_toutSup = (state_q == ACCESS);
    assign slv_select = slv_select_q;

    // Address, data and byte enables go straight through to the slaves.
    assign slv_ABus = OPB_ABus;
    assign slv_DBus = OPB_DBus;
    assign slv_BE   = OPB_BE;
    assign slv_RNW  = OPB_RNW;

endmodule
